// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the PC / next-PC unit: address width, reset and exception
// vectors, and the two-state redirect FSM encoding.
package pc_next_unit_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] EXC_PC_DEF   = 32'h0000_4180;

  typedef enum logic {
    PC_ST_RUN  = 1'b0,
    PC_ST_PEND = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_next_unit_pc_target_mux.sv
// Combinational priority select of the redirect target: exc_req (PC_EXC_VECTOR_EN only)
// > jr > jump > br_taken. Produces a valid flag plus the chosen target address.
module pc_target_mux
  import pc_next_unit_pkg::*;
#(
`ifdef PC_EXC_VECTOR_EN
  parameter logic [ADDR_W-1:0] EXC_PC = EXC_PC_DEF
`endif
) (
  input  logic [ADDR_W-1:0] pc_plus4_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_off_sh_i,
  input  logic              jump_i,
  input  logic [25:0]       j_index_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_addr_i,
`ifdef PC_EXC_VECTOR_EN
  input  logic              exc_req_i,
`endif
  output logic              redir_valid_o,
  output logic [ADDR_W-1:0] redir_tgt_o
);

  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;

  assign br_tgt = pc_plus4_i + br_off_sh_i;
  assign j_tgt  = {pc_plus4_i[31:28], j_index_i, 2'b00};

  always_comb begin
    redir_valid_o = 1'b1;
    redir_tgt_o   = '0;
`ifdef PC_EXC_VECTOR_EN
    if (exc_req_i) begin
      redir_tgt_o = EXC_PC;
    end else
`endif
    if (jr_i) begin
      redir_tgt_o = jr_addr_i;
    end else if (jump_i) begin
      redir_tgt_o = j_tgt;
    end else if (br_taken_i) begin
      redir_tgt_o = br_tgt;
    end else begin
      redir_valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selector; holds across stalls and latches any
// redirect seen during a stall. Optional exception vector enabled by PC_EXC_VECTOR_EN.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
`ifdef PC_EXC_VECTOR_EN
  ,
  parameter logic [ADDR_W-1:0] EXC_PC   = EXC_PC_DEF
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_off_sh_i,
  input  logic              jump_i,
  input  logic [25:0]       j_index_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_addr_i,
`ifdef PC_EXC_VECTOR_EN
  input  logic              exc_req_i,
`endif
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              fetch_valid_o,
  output logic              redir_pend_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_tgt_q;
  logic              fetch_valid_q;
  pc_state_e         state_q;

  logic              redir_valid;
  logic [ADDR_W-1:0] redir_tgt;

  assign pc_plus4_o = pc_q + 32'd4;

  pc_target_mux
`ifdef PC_EXC_VECTOR_EN
    #(.EXC_PC(EXC_PC))
`endif
  u_mux (
    .pc_plus4_i   (pc_plus4_o),
    .br_taken_i   (br_taken_i),
    .br_off_sh_i  (br_off_sh_i),
    .jump_i       (jump_i),
    .j_index_i    (j_index_i),
    .jr_i         (jr_i),
    .jr_addr_i    (jr_addr_i),
`ifdef PC_EXC_VECTOR_EN
    .exc_req_i    (exc_req_i),
`endif
    .redir_valid_o(redir_valid),
    .redir_tgt_o  (redir_tgt)
  );

  // The first edge after reset only raises fetch_valid so RESET_PC is fetched once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      pend_tgt_q    <= '0;
      fetch_valid_q <= 1'b0;
      state_q       <= PC_ST_RUN;
    end else if (!fetch_valid_q) begin
      fetch_valid_q <= 1'b1;
    end else begin
      case (state_q)
        PC_ST_RUN: begin
          if (!stall_i) begin
            pc_q <= redir_valid ? redir_tgt : pc_plus4_o;
          end else if (redir_valid) begin
            pend_tgt_q <= redir_tgt;
            state_q    <= PC_ST_PEND;
          end
        end
        PC_ST_PEND: begin
          if (stall_i) begin
            if (redir_valid) begin
              pend_tgt_q <= redir_tgt;
            end
          end else begin
            pc_q    <= redir_valid ? redir_tgt : pend_tgt_q;
            state_q <= PC_ST_RUN;
          end
        end
        default: state_q <= PC_ST_RUN;
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign redir_pend_o  = (state_q == PC_ST_PEND);

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural PC model. Honours PC_EXC_VECTOR_EN.
module tb_pc_next_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        brTaken;
  logic [31:0] brOff;
  logic        jump;
  logic [25:0] jIndex;
  logic        jr;
  logic [31:0] jrAddr;
  logic        excReq;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        fetchValid;
  logic        redirPend;

  int errors = 0;
  int checks = 0;

  pc_next_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .br_taken_i   (brTaken),
    .br_off_sh_i  (brOff),
    .jump_i       (jump),
    .j_index_i    (jIndex),
    .jr_i         (jr),
    .jr_addr_i    (jrAddr),
`ifdef PC_EXC_VECTOR_EN
    .exc_req_i    (excReq),
`endif
    .pc_o         (pc),
    .pc_plus4_o   (pcPlus4),
    .fetch_valid_o(fetchValid),
    .redir_pend_o (redirPend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the PC a MIPS fetch unit must hold, plus one pending-redirect slot.
  logic [31:0] mPc;
  logic [31:0] mPendTgt;
  logic        mPend;
  logic        mFv;
  logic        mKnown = 1'b0;

  always @(posedge clk) begin
    logic        hasRedir;
    logic [31:0] tgt;
    logic [31:0] seq;
    seq      = mPc + 32'd4;
    hasRedir = 1'b1;
`ifdef PC_EXC_VECTOR_EN
    if (excReq)       tgt = 32'h0000_4180;
    else
`endif
    if (jr)           tgt = jrAddr;
    else if (jump)    tgt = {seq[31:28], jIndex, 2'b00};
    else if (brTaken) tgt = seq + brOff;
    else begin
      hasRedir = 1'b0;
      tgt      = 32'h0;
    end

    if (rst) begin
      mPc    = 32'h0000_3000;
      mPend  = 1'b0;
      mFv    = 1'b0;
      mKnown = 1'b1;
    end else if (mKnown) begin
      if (!mFv) begin
        mFv = 1'b1;
      end else if (!stall) begin
        if (hasRedir)   mPc = tgt;
        else if (mPend) mPc = mPendTgt;
        else            mPc = seq;
        mPend = 1'b0;
      end else if (hasRedir) begin
        mPendTgt = tgt;
        mPend    = 1'b1;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model once reset has been seen.
  always @(negedge clk) begin
    if (mKnown) begin
      checks++;
      if (pc !== mPc || pcPlus4 !== mPc + 32'd4 || fetchValid !== mFv || redirPend !== mPend) begin
        errors++;
        $display("[TB] FAIL model: actual pc=%h pc4=%h fv=%b pend=%b required pc=%h pc4=%h fv=%b pend=%b",
                 pc, pcPlus4, fetchValid, redirPend, mPc, mPc + 32'd4, mFv, mPend);
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] off,
                               input logic j, input logic [25:0] idx,
                               input logic r, input logic [31:0] ra, input logic e);
    stall   = s;
    brTaken = b;
    brOff   = off;
    jump    = j;
    jIndex  = idx;
    jr      = r;
    jrAddr  = ra;
    excReq  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expPc,
                             input logic expFv, input logic expPend);
    checks++;
    if (pc !== expPc || fetchValid !== expFv || redirPend !== expPend) begin
      errors++;
      $display("[TB] FAIL %s: actual pc=%h fv=%b pend=%b required pc=%h fv=%b pend=%b",
               name, pc, fetchValid, redirPend, expPc, expFv, expPend);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0; brTaken = 1'b0; brOff = '0; jump = 1'b0;
    jIndex = '0; jr = 1'b0; jrAddr = '0; excReq = 1'b0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset", 32'h0000_3000, 1'b0, 1'b0);
    rst = 1'b0;

    idle(); checkOutput("first_fetch", 32'h0000_3000, 1'b1, 1'b0);
    idle(); checkOutput("seq_3004", 32'h0000_3004, 1'b1, 1'b0);
    idle(); checkOutput("seq_3008", 32'h0000_3008, 1'b1, 1'b0);
    idle(); idle(); checkOutput("seq_3010", 32'h0000_3010, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("branch_back", 32'h0000_3004, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 26'h0000100, 1'b0, 32'h0, 1'b0);
    checkOutput("jump_400", 32'h0000_0400, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_3020, 1'b0);
    checkOutput("jr_3020", 32'h0000_3020, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b1, 32'h0000_0040, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_br_latch", 32'h0000_3020, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_hold", 32'h0000_3020, 1'b1, 1'b1);
    idle(); checkOutput("pend_release", 32'h0000_3064, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_3064, 1'b0);
    checkOutput("pend_3064", 32'h0000_3064, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_5000, 1'b0);
    checkOutput("release_new_jr", 32'h0000_5000, 1'b1, 1'b0);
    idle(); checkOutput("pend_dropped", 32'h0000_5004, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 32'h0000_0008, 1'b1, 26'h0000200, 1'b1, 32'h0000_6000, 1'b0);
    checkOutput("prio_jr", 32'h0000_6000, 1'b1, 1'b0);
`ifdef PC_EXC_VECTOR_EN
    applyStimulus(1'b0, 1'b1, 32'h0000_0008, 1'b1, 26'h0000200, 1'b1, 32'h0000_6000, 1'b1);
    checkOutput("prio_exc", 32'h0000_4180, 1'b1, 1'b0);
`endif

    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 26'h0000300, 1'b0, 32'h0, 1'b0);
    checkOutput("newest_pend", pc, 1'b1, 1'b1);
    idle(); checkOutput("newest_wins", 32'h0000_0C00, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    checkOutput("jr_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    idle(); checkOutput("wrap", 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hF000_0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 26'h0000001, 1'b0, 32'h0, 1'b0);
    checkOutput("jump_region", 32'hF000_0004, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("pend_before_rst", 32'hF000_0004, 1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("rst_in_pend", 32'h0000_3000, 1'b0, 1'b0);
    rst = 1'b0;
    idle(); checkOutput("post_rst_fetch", 32'h0000_3000, 1'b1, 1'b0);
    idle(); checkOutput("post_rst_seq", 32'h0000_3004, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
